tsip_gps_link: RTL
==================

Name: tsip_gps_link

Overview:
- Second-generation TSIP link to the Thunderbolt GPS clock: configuration transmit sequencer plus byte-stuffing-aware receive deframer.
- After reset and a PPS-aligned start, sends a parametrised ROM of configuration packets.
- Then continuously deframes TSIP, filters the 8F-AB timing packet, and publishes UTC date/time, week, UTC offset and timing flags.
- Sits between the board UART pins and the pulse_generator blocks and register map; also reports framing errors and missing-packet timeouts.

Parameters:
- CLKS_PER_BIT, 1042, UART bit period in i_clk cycles (10 MHz / 9600).
- CFG_DEPTH, 16, configuration ROM entries (bytes incl. DLE/ETX framing, unstuffed payload stored pre-stuffed); valid range 1..64.
- RX_MAX_LEN, 32, max destuffed bytes buffered per packet (ID excluded).
- TIM_ID, 8'h8F, timing packet ID.
- TIM_SUB, 8'hAB, timing packet subcode.
- PPS_WAIT, 1, PPS rising edges to wait after reset before transmitting.
- TIMEOUT_S, 3, PPS edges without a valid timing packet before o_timeout asserts.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_pps_raw  in  1  raw PPS from GPS, asynchronous
- i_rx_thunder  in  1  serial from GPS
- o_tx_thunder  out  1  serial to GPS, idle high
- i_resend  in  1  one-cycle pulse: re-run config sequence
- o_cfg_done  out  1  high once the last ROM byte's stop bit has completed
- o_thunder_packet_dv  out  1  one-cycle strobe, fields below updated
- o_thunder_year  out  16  year (year_h:year_l)
- o_thunder_month, o_thunder_day, o_thunder_hour, o_thunder_minutes, o_thunder_seconds  out  8 each  UTC fields
- o_thunder_week  out  16  GPS week
- o_thunder_utc_offset  out  16  UTC offset, signed
- o_thunder_flags  out  8  timing flag byte
- o_frame_err  out  1  one-cycle strobe on a malformed frame
- o_timeout  out  1  level: no valid timing packet in TIMEOUT_S seconds

Behaviour:
- Reset: all outputs 0 except o_tx_thunder=1; FSMs in IDLE; buffers and counters cleared. Reset mid-transmission aborts the current byte, with the line driven idle within one cycle.
- PPS: 2-flop synchroniser, then rising-edge detect producing pps_rise, a one-cycle pulse.
- TX FSM states:
  - WAIT_PPS: count pps_rise to PPS_WAIT, then LOAD.
  - LOAD: byte = rom[idx], then SEND.
  - SEND: pulse tx_dv for 1 cycle, then WAIT_DONE.
  - WAIT_DONE: on tx_done go to NEXT.
  - NEXT: idx++; if idx == CFG_DEPTH go to DONE, else LOAD.
  - DONE: o_cfg_done=1.
  - i_resend in DONE: idx=0, o_cfg_done=0, go to LOAD with no PPS wait. i_resend in any other state is ignored.
- ROM default contents: 10 8E A2 01 10 03 10 8E A5 00 01 00 00 10 03, padded with 8'hFF entries that are skipped (NEXT without SEND).
- RX deframer states: HUNT, DLE1, BODY, BODY_DLE. Runs from reset, independent of TX.
  - HUNT: on 10 go to DLE1.
  - DLE1: 10 or 03 goes to HUNT; anything else is the ID, latched, then BODY.
  - BODY: 10 goes to BODY_DLE; other bytes are stored at wr_ptr++.
  - BODY_DLE: 10 stores a literal 10 and returns to BODY; 03 ends the packet; anything else asserts o_frame_err and goes to DLE1, treating that byte as the new ID.
- Overflow: wr_ptr reaching RX_MAX_LEN gives o_frame_err and HUNT.
- End of packet: if ID==TIM_ID, buf[0]==TIM_SUB and length==17, then the cycle after ETX:
  - Update fields: week=buf[5:6], offset=buf[7:8], flags=buf[9], sec=buf[10], min=buf[11], hour=buf[12], day=buf[13], month=buf[14], year=buf[15:16]. Multi-byte fields are big-endian.
  - Pulse o_thunder_packet_dv.
  - Other IDs are dropped silently. 8F-AB with a wrong length gives o_frame_err.
- Timeout: 3-bit counter increments on pps_rise and saturates; it clears on packet_dv. o_timeout = (cnt >= TIMEOUT_S). If pps_rise and packet_dv occur in the same cycle, the clear wins.
- Fields hold their last value until the next valid packet.

Optional Feature:
- TSIP_AUTO_RESEND_EN defined: when o_timeout rises while the TX FSM is in DONE, the block performs an internal i_resend, re-sending the configuration once per timeout episode. It re-arms only after a valid packet.
- Undefined: the configuration is re-sent only via i_resend.

Decomposition:
- Package tsip_pkg holds:
  - DLE/ETX constants
  - TX and RX state encodings
  - 8F-AB field byte offsets
  - default config ROM contents
- Natural sub-module: tsip_deframer (RX FSM + buffer, outputs id/len/buffer/eop/err).
- The top instantiates uart_rx, uart_tx and tsip_deframer, and holds the TX sequencer, field extraction and timeout logic.

Test Plan:
- Reset, then 1 PPS -> o_tx_thunder carries the 15 ROM bytes in order, each with 1 start + 8 data + 1 stop bit; o_cfg_done rises after the final 03.
- Drive 10 8F AB 00 01 51 80 08 9C 00 12 03 1E 0D 0A 0F 07 07 E8 10 03 -> single dv strobe with week=0x089C, offset=18, flags=03, seconds=30, minutes=13, hour=10, day=15, month=7, year=2024.
- Same packet with TOW byte 10 sent as 10 10 -> identical fields; with a lone 10 followed by 55 in the body -> o_frame_err, no dv.
- 10 8F AC ... 10 03 -> no dv, no error; fields unchanged.
- No packets for 3 PPS -> o_timeout=1; a valid packet clears it. With TSIP_AUTO_RESEND_EN, the config is retransmitted exactly once.
- Assert i_rst during the 5th TX byte -> line idle next cycle; after release the sequence restarts from byte 0 following PPS_WAIT.

Source files
------------

// File: rtl/tsip_pkg.sv
// Shared TSIP constants, state encodings, 8F-AB layout and config ROM.
// Used by the tsip_gps_link top and the tsip_deframer receive path.
package tsip_pkg;

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;
  localparam logic [7:0] PAD = 8'hFF;

  typedef enum logic [2:0] {
    TX_WAIT_PPS,
    TX_LOAD,
    TX_SEND,
    TX_WAIT_DONE,
    TX_NEXT,
    TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_DLE1,
    RX_BODY,
    RX_BODY_DLE
  } rx_state_t;

  // Byte offsets into the destuffed 8F-AB body (subcode at 0)
  localparam int OFS_SUB   = 0;
  localparam int OFS_WEEK  = 5;
  localparam int OFS_UTC   = 7;
  localparam int OFS_FLAGS = 9;
  localparam int OFS_SEC   = 10;
  localparam int OFS_MIN   = 11;
  localparam int OFS_HOUR  = 12;
  localparam int OFS_DAY   = 13;
  localparam int OFS_MONTH = 14;
  localparam int OFS_YEAR  = 15;
  localparam int TIM_LEN   = 17;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
    logic [15:0] week;
    logic [15:0] utc;
    logic [7:0]  flags;
  } tim_fields_t;

  // Pre-stuffed config stream; PAD entries are skipped by the sequencer
  function automatic logic [7:0] cfg_rom(input logic [6:0] idx);
    logic [7:0] b;
    case (idx)
      7'd0:    b = 8'h10;
      7'd1:    b = 8'h8E;
      7'd2:    b = 8'hA2;
      7'd3:    b = 8'h01;
      7'd4:    b = 8'h10;
      7'd5:    b = 8'h03;
      7'd6:    b = 8'h10;
      7'd7:    b = 8'h8E;
      7'd8:    b = 8'hA5;
      7'd9:    b = 8'h00;
      7'd10:   b = 8'h01;
      7'd11:   b = 8'h00;
      7'd12:   b = 8'h00;
      7'd13:   b = 8'h10;
      7'd14:   b = 8'h03;
      default: b = PAD;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tsip_deframer.sv
// TSIP receive deframer: DLE destuffing, ID latch and body buffer.
// Emits eop with id/len/buffer on DLE-ETX, err on malformed frames.
module tsip_deframer
  import tsip_pkg::*;
#(
  parameter int RX_MAX_LEN = 32
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_dv,
  input  logic [7:0]                          i_byte,
  output logic [7:0]                          o_id,
  output logic [$clog2(RX_MAX_LEN+1)-1:0]     o_len,
  output logic [RX_MAX_LEN-1:0][7:0]          o_buf,
  output logic                                o_eop,
  output logic                                o_err
);

  localparam int LW = $clog2(RX_MAX_LEN + 1);
  localparam int IW = $clog2(RX_MAX_LEN);

  rx_state_t                  r_state;
  logic [7:0]                 r_id;
  logic [LW-1:0]              r_ptr;
  logic [RX_MAX_LEN-1:0][7:0] r_buf;
  logic                       r_eop;
  logic                       r_err;

  logic [IW-1:0] w_idx;
  logic          w_last;

  assign w_idx  = r_ptr[IW-1:0];
  assign w_last = (r_ptr == LW'(RX_MAX_LEN - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RX_HUNT;
      r_id    <= '0;
      r_ptr   <= '0;
      r_buf   <= '0;
      r_eop   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_eop <= 1'b0;
      r_err <= 1'b0;
      if (i_dv) begin
        unique case (r_state)
          RX_HUNT: begin
            if (i_byte == DLE) r_state <= RX_DLE1;
          end
          RX_DLE1: begin
            if (i_byte == DLE || i_byte == ETX) begin
              r_state <= RX_HUNT;
            end else begin
              r_id    <= i_byte;
              r_ptr   <= '0;
              r_state <= RX_BODY;
            end
          end
          RX_BODY: begin
            if (i_byte == DLE) begin
              r_state <= RX_BODY_DLE;
            end else begin
              r_buf[w_idx] <= i_byte;
              if (w_last) begin
                r_err   <= 1'b1;
                r_state <= RX_HUNT;
              end else begin
                r_ptr <= r_ptr + 1'b1;
              end
            end
          end
          RX_BODY_DLE: begin
            if (i_byte == DLE) begin
              r_buf[w_idx] <= DLE;
              if (w_last) begin
                r_err   <= 1'b1;
                r_state <= RX_HUNT;
              end else begin
                r_ptr   <= r_ptr + 1'b1;
                r_state <= RX_BODY;
              end
            end else if (i_byte == ETX) begin
              r_eop   <= 1'b1;
              r_state <= RX_HUNT;
            end else begin
              // Unstuffed DLE: resync with this byte as a fresh packet ID
              r_err   <= 1'b1;
              r_id    <= i_byte;
              r_ptr   <= '0;
              r_state <= RX_BODY;
            end
          end
          default: r_state <= RX_HUNT;
        endcase
      end
    end
  end

  assign o_id  = r_id;
  assign o_len = r_ptr;
  assign o_buf = r_buf;
  assign o_eop = r_eop;
  assign o_err = r_err;

endmodule

// File: rtl/tsip_gps_link_uart.sv
// 8N1 UART receiver and transmitter for the Thunderbolt TSIP link.
// Both idle high; the receiver samples mid-bit after a 2-flop sync.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_dv,
  output logic [7:0] o_byte
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } urx_state_t;

  urx_state_t     r_state;
  logic [1:0]     r_sync;
  logic [CW-1:0]  r_clk;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           r_dv;
  logic [7:0]     r_byte;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= U_IDLE;
      r_sync  <= 2'b11;
      r_clk   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dv    <= 1'b0;
      r_byte  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_dv   <= 1'b0;
      unique case (r_state)
        U_IDLE: begin
          r_clk <= '0;
          r_bit <= '0;
          if (!r_sync[1]) r_state <= U_START;
        end
        U_START: begin
          if (r_clk == HALF) begin
            r_clk   <= '0;
            r_state <= r_sync[1] ? U_IDLE : U_DATA;
          end else begin
            r_clk <= r_clk + 1'b1;
          end
        end
        U_DATA: begin
          if (r_clk == LAST) begin
            r_clk   <= '0;
            r_shift <= {r_sync[1], r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= U_STOP;
            else r_bit <= r_bit + 1'b1;
          end else begin
            r_clk <= r_clk + 1'b1;
          end
        end
        U_STOP: begin
          if (r_clk == LAST) begin
            r_clk   <= '0;
            r_state <= U_IDLE;
            if (r_sync[1]) begin
              r_dv   <= 1'b1;
              r_byte <= r_shift;
            end
          end else begin
            r_clk <= r_clk + 1'b1;
          end
        end
        default: r_state <= U_IDLE;
      endcase
    end
  end

  assign o_dv   = r_dv;
  assign o_byte = r_byte;

endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dv,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          r_busy;
  logic [8:0]    r_shift;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_clk;
  logic          r_tx;
  logic          r_done;

  // Start bit goes out on load; each period end shifts the next bit out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_shift <= '0;
      r_bit   <= '0;
      r_clk   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_dv) begin
          r_busy  <= 1'b1;
          r_shift <= {1'b1, i_byte};
          r_bit   <= '0;
          r_clk   <= '0;
          r_tx    <= 1'b0;
        end
      end else if (r_clk == LAST) begin
        r_clk <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_tx   <= 1'b1;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 1'b1;
        end
      end else begin
        r_clk <= r_clk + 1'b1;
      end
    end
  end

  assign o_tx   = r_tx;
  assign o_done = r_done;

endmodule

// File: rtl/tsip_gps_link.sv
// Thunderbolt TSIP link: PPS-aligned config sequencer, 8F-AB decode, timeout.
// Optional TSIP_AUTO_RESEND_EN: re-send config once per timeout episode.
module tsip_gps_link
  import tsip_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1042,
  parameter int         CFG_DEPTH    = 16,
  parameter int         RX_MAX_LEN   = 32,
  parameter logic [7:0] TIM_ID       = 8'h8F,
  parameter logic [7:0] TIM_SUB      = 8'hAB,
  parameter int         PPS_WAIT     = 1,
  parameter int         TIMEOUT_S    = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pps_raw,
  input  logic        i_rx_thunder,
  output logic        o_tx_thunder,
  input  logic        i_resend,
  output logic        o_cfg_done,
  output logic        o_thunder_packet_dv,
  output logic [15:0] o_thunder_year,
  output logic [7:0]  o_thunder_month,
  output logic [7:0]  o_thunder_day,
  output logic [7:0]  o_thunder_hour,
  output logic [7:0]  o_thunder_minutes,
  output logic [7:0]  o_thunder_seconds,
  output logic [15:0] o_thunder_week,
  output logic [15:0] o_thunder_utc_offset,
  output logic [7:0]  o_thunder_flags,
  output logic        o_frame_err,
  output logic        o_timeout
);

  localparam int LW = $clog2(RX_MAX_LEN + 1);
  localparam logic [6:0] DEPTH7 = 7'(CFG_DEPTH);
  localparam logic [7:0] WAIT8  = 8'(PPS_WAIT);
  localparam logic [2:0] TO3    = 3'(TIMEOUT_S);

  logic [1:0] r_pps_sync;
  logic       r_pps_d;
  logic       w_pps_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pps_sync <= '0;
      r_pps_d    <= 1'b0;
    end else begin
      r_pps_sync <= {r_pps_sync[0], i_pps_raw};
      r_pps_d    <= r_pps_sync[1];
    end
  end

  assign w_pps_rise = r_pps_sync[1] & ~r_pps_d;

  logic       w_rx_dv;
  logic [7:0] w_rx_byte;
  logic       w_tx_done;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rx   (i_rx_thunder),
    .o_dv   (w_rx_dv),
    .o_byte (w_rx_byte)
  );

  tx_state_t  r_tx_state;
  logic [6:0] r_idx;
  logic [7:0] r_pps_cnt;
  logic [7:0] r_byte;
  logic       r_tx_dv;
  logic       r_cfg_done;
  logic [7:0] w_rom;
  logic       w_resend;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_dv   (r_tx_dv),
    .i_byte (r_byte),
    .o_tx   (o_tx_thunder),
    .o_done (w_tx_done)
  );

  assign w_rom = cfg_rom(r_idx);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_WAIT_PPS;
      r_idx      <= '0;
      r_pps_cnt  <= '0;
      r_byte     <= '0;
      r_tx_dv    <= 1'b0;
      r_cfg_done <= 1'b0;
    end else begin
      r_tx_dv <= 1'b0;
      unique case (r_tx_state)
        TX_WAIT_PPS: begin
          if (r_pps_cnt >= WAIT8) begin
            r_idx      <= '0;
            r_tx_state <= TX_LOAD;
          end else if (w_pps_rise) begin
            r_pps_cnt <= r_pps_cnt + 1'b1;
          end
        end
        TX_LOAD: begin
          r_byte     <= w_rom;
          r_tx_state <= (w_rom == PAD) ? TX_NEXT : TX_SEND;
        end
        TX_SEND: begin
          r_tx_dv    <= 1'b1;
          r_tx_state <= TX_WAIT_DONE;
        end
        TX_WAIT_DONE: begin
          if (w_tx_done) r_tx_state <= TX_NEXT;
        end
        TX_NEXT: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx + 7'd1 == DEPTH7) begin
            r_cfg_done <= 1'b1;
            r_tx_state <= TX_DONE;
          end else begin
            r_tx_state <= TX_LOAD;
          end
        end
        TX_DONE: begin
          if (w_resend) begin
            r_idx      <= '0;
            r_cfg_done <= 1'b0;
            r_tx_state <= TX_LOAD;
          end
        end
        default: r_tx_state <= TX_WAIT_PPS;
      endcase
    end
  end

  logic [7:0]                 w_id;
  logic [LW-1:0]              w_len;
  logic [RX_MAX_LEN-1:0][7:0] w_buf;
  logic                       w_eop;
  logic                       w_df_err;

  tsip_deframer #(.RX_MAX_LEN(RX_MAX_LEN)) u_deframer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_dv   (w_rx_dv),
    .i_byte (w_rx_byte),
    .o_id   (w_id),
    .o_len  (w_len),
    .o_buf  (w_buf),
    .o_eop  (w_eop),
    .o_err  (w_df_err)
  );

  logic w_is_tim;
  logic w_good;
  logic w_badlen;
  logic w_unused_buf;

  assign w_is_tim = (w_id == TIM_ID) && (w_buf[OFS_SUB] == TIM_SUB);
  assign w_good   = w_eop & w_is_tim & (w_len == LW'(TIM_LEN));
  assign w_badlen = w_eop & w_is_tim & (w_len != LW'(TIM_LEN));
  assign w_unused_buf = ^w_buf;

  tim_fields_t r_fld;
  logic        r_dv;
  logic        r_ferr;
  logic [2:0]  r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fld    <= '0;
      r_dv     <= 1'b0;
      r_ferr   <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_dv   <= w_good;
      r_ferr <= w_df_err | w_badlen;
      if (w_good) begin
        r_fld.week    <= {w_buf[OFS_WEEK], w_buf[OFS_WEEK+1]};
        r_fld.utc     <= {w_buf[OFS_UTC], w_buf[OFS_UTC+1]};
        r_fld.flags   <= w_buf[OFS_FLAGS];
        r_fld.seconds <= w_buf[OFS_SEC];
        r_fld.minutes <= w_buf[OFS_MIN];
        r_fld.hour    <= w_buf[OFS_HOUR];
        r_fld.day     <= w_buf[OFS_DAY];
        r_fld.month   <= w_buf[OFS_MONTH];
        r_fld.year    <= {w_buf[OFS_YEAR], w_buf[OFS_YEAR+1]};
      end
      // A packet in the same cycle as a PPS edge takes priority
      if (r_dv) r_to_cnt <= '0;
      else if (w_pps_rise && r_to_cnt != 3'd7) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  logic w_timeout;
  assign w_timeout = (r_to_cnt >= TO3);

`ifdef TSIP_AUTO_RESEND_EN
  logic r_to_d;
  logic r_armed;
  logic w_to_rise;

  assign w_to_rise = w_timeout & ~r_to_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_d  <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_to_d <= w_timeout;
      if (r_dv) r_armed <= 1'b1;
      else if (w_to_rise) r_armed <= 1'b0;
    end
  end

  assign w_resend = i_resend |
    (w_to_rise & r_armed & (r_tx_state == TX_DONE));
`else
  assign w_resend = i_resend;
`endif

  assign o_cfg_done           = r_cfg_done;
  assign o_thunder_packet_dv  = r_dv;
  assign o_thunder_year       = r_fld.year;
  assign o_thunder_month      = r_fld.month;
  assign o_thunder_day        = r_fld.day;
  assign o_thunder_hour       = r_fld.hour;
  assign o_thunder_minutes    = r_fld.minutes;
  assign o_thunder_seconds    = r_fld.seconds;
  assign o_thunder_week       = r_fld.week;
  assign o_thunder_utc_offset = r_fld.utc;
  assign o_thunder_flags      = r_fld.flags;
  assign o_frame_err          = r_ferr;
  assign o_timeout            = w_timeout;

endmodule
